// File: rtl/call_button_conditioner.sv
// call_button_conditioner
// Conditions the raw passenger call/cancel buttons for the call-light FSM.
// Each channel runs through a two-flop synchronizer and a debounce counter
// into a clean level. A single-cycle pulse marks each debounced press.
// Optional feature: define BUTTON_LOCKOUT_EN to suppress press pulses for
// LOCKOUT_CYCLES after each pulse. Levels are never affected by the lockout.
// Channel index 0 is call and index 1 is cncl.
module call_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic call_raw,
    input  logic cncl_raw,
    output logic call,
    output logic cncl,
    output logic call_level,
    output logic cncl_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Out-of-range parameters are rejected at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 1..255");
    end
    if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 65535) begin : g_bad_lockout
        $error("LOCKOUT_CYCLES must be in 1..65535");
    end

    logic [1:0]       raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       level_q;
    logic [1:0]       level_d;
    logic [1:0]       pulse_q;
    logic [1:0]       pulse_d;
    logic [1:0]       rise;

    assign raw = {cncl_raw, call_raw};

`ifdef BUTTON_LOCKOUT_EN
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

    logic [LOCK_W-1:0] lock_q [2];
    logic [LOCK_W-1:0] lock_d [2];
`endif

    // Debounce decision, press detection and lockout timing for both channels.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = '0;
        rise    = '0;
`ifdef BUTTON_LOCKOUT_EN
        lock_d  = lock_q;
`endif
        for (int ch = 0; ch < 2; ch++) begin
            if (sync2_q[ch] == level_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                level_d[ch] = sync2_q[ch];
                cnt_d[ch]   = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_ONE;
            end

            rise[ch] = level_d[ch] & ~level_q[ch];

`ifdef BUTTON_LOCKOUT_EN
            // A press inside the window still moves the level, but is not an event.
            pulse_d[ch] = rise[ch] && (lock_q[ch] == '0);
            if (pulse_d[ch]) begin
                lock_d[ch] = LOCK_LOAD;
            end else if (lock_q[ch] != '0) begin
                lock_d[ch] = lock_q[ch] - LOCK_ONE;
            end
`else
            pulse_d[ch] = rise[ch];
`endif
        end
    end

    // State registers with synchronous reset; the sync flops are reset too so
    // a button held through reset is re-debounced from scratch.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            level_q  <= '0;
            pulse_q  <= '0;
`ifdef BUTTON_LOCKOUT_EN
            lock_q[0] <= '0;
            lock_q[1] <= '0;
`endif
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
`ifdef BUTTON_LOCKOUT_EN
            lock_q   <= lock_d;
`endif
        end
    end

    assign call       = pulse_q[0];
    assign cncl       = pulse_q[1];
    assign call_level = level_q[0];
    assign cncl_level = level_q[1];

endmodule
